// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : boot_loader
//  Purpose  : Copies a length-prefixed image from an SPI EEPROM (mode 0,
//             clk/2) into external SRAM via a one-cycle write strobe, then
//             raises o_isBooted and holds until reset.
//  Revision : 1.0  initial release
// ============================================================================
module boot_loader #(
   parameter logic [7:0]  CMD_READ  = 8'h03,
   parameter logic [15:0] MAX_WORDS = 16'hC000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_spiCs_n,
   output logic        o_spiSck,
   output logic        o_spiMosi,
   input  logic        i_spiMiso,
   output logic [15:0] o_bootAddr,
   output logic [15:0] o_bootData,
   output logic        o_bootEn,
   output logic        o_isBooted
);

   // Read opcode followed by a 24-bit start address of zero.
   localparam logic [31:0] CMD_WORD = {CMD_READ, 24'h000000};

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CMD  = 3'd1,
      LEN  = 3'd2,
      DATA = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t      state;
   logic [4:0]  bit_cnt;     // bit index within the current field
   logic [30:0] tx_shift;    // command bits still to be sent, MSB next
   logic [14:0] rx_shift;    // partially received length/data word
   logic [15:0] word_idx;    // index of the word currently shifting in
   logic [15:0] count;       // effective word count, clamped to MAX_WORDS
   logic        last_word;   // final strobe issued; next cycle is DONE
   logic [15:0] rx_next;

   // Received word including the bit sampled on this edge.
   assign rx_next = {rx_shift, i_spiMiso};

   // Boot sequencer: SPI framing, length capture and SRAM write strobes.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         bit_cnt    <= 5'd0;
         tx_shift   <= 31'd0;
         rx_shift   <= 15'd0;
         word_idx   <= 16'd0;
         count      <= 16'd0;
         last_word  <= 1'b0;
         o_spiCs_n  <= 1'b1;
         o_spiSck   <= 1'b0;
         o_spiMosi  <= 1'b0;
         o_bootAddr <= 16'd0;
         o_bootData <= 16'd0;
         o_bootEn   <= 1'b0;
         o_isBooted <= 1'b0;
      end else begin
         o_bootEn <= 1'b0;
         case (state)
            IDLE: begin
               // Select the EEPROM and present the first command bit
               // during the first SCK-low cycle.
               state     <= CMD;
               o_spiCs_n <= 1'b0;
               o_spiSck  <= 1'b0;
               o_spiMosi <= CMD_WORD[31];
               tx_shift  <= CMD_WORD[30:0];
               bit_cnt   <= 5'd0;
            end

            CMD: begin
               if (!o_spiSck) begin
                  o_spiSck <= 1'b1;
               end else begin
                  // End of an SCK-high cycle: MOSI advances only here.
                  o_spiSck <= 1'b0;
                  if (bit_cnt == 5'd31) begin
                     state     <= LEN;
                     bit_cnt   <= 5'd0;
                     o_spiMosi <= 1'b0;
                  end else begin
                     bit_cnt   <= bit_cnt + 5'd1;
                     o_spiMosi <= tx_shift[30];
                     tx_shift  <= {tx_shift[29:0], 1'b0};
                  end
               end
            end

            LEN: begin
               if (!o_spiSck) begin
                  o_spiSck <= 1'b1;
               end else begin
                  o_spiSck <= 1'b0;
                  rx_shift <= rx_next[14:0];
                  if (bit_cnt == 5'd15) begin
                     bit_cnt <= 5'd0;
                     if (rx_next == 16'd0) begin
                        // Empty image: nothing to copy.
                        state      <= DONE;
                        o_spiCs_n  <= 1'b1;
                        o_isBooted <= 1'b1;
                     end else begin
                        state <= DATA;
                        count <= (rx_next > MAX_WORDS) ? MAX_WORDS : rx_next;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end

            DATA: begin
               if (last_word) begin
                  // Strobe cycle of the final word has elapsed; stop the
                  // SPI transaction without further SCK edges.
                  state      <= DONE;
                  o_spiCs_n  <= 1'b1;
                  o_spiSck   <= 1'b0;
                  o_isBooted <= 1'b1;
               end else if (!o_spiSck) begin
                  o_spiSck <= 1'b1;
               end else begin
                  o_spiSck <= 1'b0;
                  rx_shift <= rx_next[14:0];
                  if (bit_cnt == 5'd15) begin
                     // Word complete: publish it while the next word
                     // starts shifting into rx_shift.
                     bit_cnt    <= 5'd0;
                     o_bootEn   <= 1'b1;
                     o_bootData <= rx_next;
                     o_bootAddr <= word_idx;
                     word_idx   <= word_idx + 16'd1;
                     if (word_idx == count - 16'd1) begin
                        last_word <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end

            DONE: begin
               // Terminal state; everything holds until reset.
               o_spiCs_n  <= 1'b1;
               o_spiSck   <= 1'b0;
               o_spiMosi  <= 1'b0;
               o_isBooted <= 1'b1;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_boot_loader
//  Purpose  : Self-checking bench for boot_loader with a bit-level SPI
//             EEPROM model and an image-level reference of expected writes.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_boot_loader;

   localparam logic [15:0] MAXW    = 16'd24;
   localparam logic [31:0] EXP_CMD = 32'h0300_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_cs_n, spi_sck, spi_mosi;
   logic        spi_miso = 1'b0;
   logic [15:0] boot_addr, boot_data;
   logic        boot_en, is_booted;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic prev_mosi = 1'b0;
   logic prev_en   = 1'b0;

   // EEPROM image: length word followed by data_tab[0..]
   logic [15:0] model_n = 16'd0;
   logic [15:0] data_tab [64];
   logic [31:0] cmd_cap = 32'd0;
   int          bitpos  = 0;
   logic        mdl_prev_cs = 1'b1;

   boot_loader #(
      .CMD_READ  (8'h03),
      .MAX_WORDS (MAXW)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .o_spiCs_n  (spi_cs_n),
      .o_spiSck   (spi_sck),
      .o_spiMosi  (spi_mosi),
      .i_spiMiso  (spi_miso),
      .o_bootAddr (boot_addr),
      .o_bootData (boot_data),
      .o_bootEn   (boot_en),
      .o_isBooted (is_booted)
   );

   always #5 clk = ~clk;

   // Bit at stream position pos (0..31 are the command slots, don't care).
   function automatic logic stream_bit(input int pos);
      int p, w, b;
      logic [15:0] word;
      if (pos < 32) return 1'($urandom);
      p = pos - 32;
      w = p / 16;
      b = 15 - (p % 16);
      word = (w == 0) ? model_n : data_tab[(w - 1) % 64];
      return word[b];
   endfunction

   // EEPROM model: drives MISO during SCK-low cycles, captures MOSI on
   // SCK-high cycles, random MISO while deselected.
   always @(negedge clk) begin
      if (spi_cs_n) begin
         spi_miso = 1'($urandom);
         bitpos   = 0;
      end else begin
         if (mdl_prev_cs) cmd_cap = 32'd0;
         if (!spi_sck) begin
            spi_miso = stream_bit(bitpos);
         end else begin
            if (bitpos < 32) cmd_cap = {cmd_cap[30:0], spi_mosi};
            bitpos = bitpos + 1;
         end
      end
      mdl_prev_cs = spi_cs_n;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, sample at the falling edge, check bus invariants.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (spi_cs_n) chk("sck_while_cs_high", {31'd0, spi_sck}, 32'd0);
      if (spi_sck)  chk("mosi_stable_sck_high", {31'd0, spi_mosi}, {31'd0, prev_mosi});
      chk("en_single_cycle", {31'd0, boot_en & prev_en}, 32'd0);
      prev_mosi = spi_mosi;
      prev_en   = boot_en;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 64; i++) data_tab[i] = 16'($urandom);
   endtask

   // Reset, boot an image of length n, check every write and the DONE state.
   // abort_rel >= 0 asserts reset during that cycle after IDLE instead.
   task automatic run_boot(input logic [15:0] n, input int abort_rel, input int hold);
      int cnt, t0, rel, k, budget, exp_done;
      logic seen_done, aborted;
      logic [15:0] exp_addr, exp_data;
      model_n = n;
      cnt = (n > MAXW) ? int'(MAXW) : int'(n);
      rst = 1'b1;
      tick();
      tick();
      chk("rst_cs_n",  {31'd0, spi_cs_n},  32'd1);
      chk("rst_sck",   {31'd0, spi_sck},   32'd0);
      chk("rst_mosi",  {31'd0, spi_mosi},  32'd0);
      chk("rst_en",    {31'd0, boot_en},   32'd0);
      chk("rst_booted",{31'd0, is_booted}, 32'd0);
      chk("rst_addr",  {16'd0, boot_addr}, 32'd0);
      chk("rst_data",  {16'd0, boot_data}, 32'd0);
      rst = 1'b0;
      t0 = cyc;                       // this sampled cycle is the IDLE cycle
      k = 0;
      seen_done = 1'b0;
      aborted = 1'b0;
      budget = 200 + 32 * cnt;
      exp_done = (cnt == 0) ? 97 : (129 + 32 * (cnt - 1) + 1);
      for (int c = 0; c < budget; c++) begin
         tick();
         rel = cyc - t0;
         if (rel == 1) chk("cs_low_after_idle", {31'd0, spi_cs_n}, 32'd0);
         if (rel >= 65 && !is_booted) chk("mosi_zero_len_data", {31'd0, spi_mosi}, 32'd0);
         if (boot_en) begin
            chk("strobe_addr", {16'd0, boot_addr}, 32'(k));
            chk("strobe_data", {16'd0, boot_data}, {16'd0, data_tab[k % 64]});
            chk("strobe_time", 32'(rel), 32'(129 + 32 * k));
            k++;
         end
         if (rel == abort_rel) begin
            rst = 1'b1;
            tick();
            chk("abort_cs_high", {31'd0, spi_cs_n}, 32'd1);
            chk("abort_no_strobe", {31'd0, boot_en}, 32'd0);
            chk("abort_strobes_so_far", 32'(k), 32'd1);
            aborted = 1'b1;
            break;
         end
         if (is_booted) begin
            seen_done = 1'b1;
            chk("done_time", 32'(rel), 32'(exp_done));
            chk("strobe_count", 32'(k), 32'(cnt));
            chk("cmd_bits", cmd_cap, EXP_CMD);
            break;
         end
      end
      if (!aborted) begin
         chk("done_reached", {31'd0, seen_done}, 32'd1);
         exp_addr = (cnt == 0) ? 16'd0 : 16'(cnt - 1);
         exp_data = (cnt == 0) ? 16'd0 : data_tab[cnt - 1];
         for (int h = 0; h < hold; h++) begin
            tick();
            chk("done_cs",     {31'd0, spi_cs_n},  32'd1);
            chk("done_sck",    {31'd0, spi_sck},   32'd0);
            chk("done_mosi",   {31'd0, spi_mosi},  32'd0);
            chk("done_en",     {31'd0, boot_en},   32'd0);
            chk("done_booted", {31'd0, is_booted}, 32'd1);
            chk("done_addr",   {16'd0, boot_addr}, {16'd0, exp_addr});
            chk("done_data",   {16'd0, boot_data}, {16'd0, exp_data});
         end
      end
   endtask

   initial begin
      fill_random();
      // Reference image with three known words, long DONE hold.
      data_tab[0] = 16'h1234;
      data_tab[1] = 16'hABCD;
      data_tab[2] = 16'h0001;
      run_boot(16'd3, -1, 1000);
      // Empty image.
      fill_random();
      run_boot(16'd0, -1, 20);
      // Oversized length clamps to the ceiling.
      fill_random();
      run_boot(16'hFFFF, -1, 10);
      // Exactly at and one past the ceiling.
      fill_random();
      run_boot(MAXW, -1, 5);
      fill_random();
      run_boot(MAXW + 16'd1, -1, 5);
      // Single word and random lengths.
      fill_random();
      run_boot(16'd1, -1, 5);
      for (int r = 0; r < 3; r++) begin
         fill_random();
         run_boot(16'($urandom_range(30, 1)), -1, 5);
      end
      // Reset during bit 7 of word 1, then a full reboot of the same image.
      fill_random();
      data_tab[0] = 16'h1234;
      data_tab[1] = 16'hABCD;
      data_tab[2] = 16'h0001;
      run_boot(16'd3, 130 + 2 * 7, 0);
      run_boot(16'd3, -1, 5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
